// File: rtl/mux_pkg.sv
// Shared constants for the emulator datapath select mux (mux_8_1).
package mux_pkg;

  localparam int unsigned MUX_DEFAULT_WIDTH = 8;

  // Select encoding: S=1 picks A, S=0 picks B.
  localparam logic SEL_A = 1'b1;
  localparam logic SEL_B = 1'b0;

endpackage

// File: rtl/mux_8_1_reg.sv
// WIDTH-bit register with synchronous active-high reset and load enable.
import mux_pkg::*;

module mux_8_1_reg #(
  parameter int unsigned WIDTH = MUX_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Reset wins over enable; otherwise load on enable, else hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/mux_8_1.sv
// Two-input select mux: value = S ? A : B (combinational), plus a
// registered copy value_q with sync reset and load enable.
// Optional MUX_8_1_PARITY_EN adds parity / parity_q outputs.
import mux_pkg::*;

module mux_8_1 #(
  parameter int unsigned WIDTH = MUX_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             S,
  input  logic             en,
`ifdef MUX_8_1_PARITY_EN
  output logic             parity,
  output logic             parity_q,
`endif
  output logic [WIDTH-1:0] value,
  output logic [WIDTH-1:0] value_q
);

  // Ternary select keeps X-merge behaviour on an unknown S (agreeing bits pass).
  assign value = S ? A : B;

  mux_8_1_reg #(.WIDTH(WIDTH)) u_value_reg (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .d     (value),
    .q     (value_q)
  );

`ifdef MUX_8_1_PARITY_EN
  // Even-parity bit of the selected data, registered alongside value_q.
  assign parity = ^value;

  mux_8_1_reg #(.WIDTH(1)) u_parity_reg (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .d     (parity),
    .q     (parity_q)
  );
`endif

endmodule

// File: tb/tb_mux_8_1.sv
// Self-checking bench for mux_8_1: directed vectors plus a per-cycle
// comparison against a behavioural model of the select and register.
import mux_pkg::*;

module tb_mux_8_1;

  localparam int unsigned W = MUX_DEFAULT_WIDTH;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         S = SEL_B;
  logic         en = 1'b0;
  logic [W-1:0] value;
  logic [W-1:0] value_q;
`ifdef MUX_8_1_PARITY_EN
  logic         parity;
  logic         parity_q;
`endif

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;
  bit          done  = 1'b0;

  mux_8_1 #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset   (reset),
    .A       (A),
    .B       (B),
    .S       (S),
    .en      (en),
`ifdef MUX_8_1_PARITY_EN
    .parity  (parity),
    .parity_q(parity_q),
`endif
    .value   (value),
    .value_q (value_q)
  );

  always #5 clk = ~clk;

  // Model: the select as bit masking, and the register as a remembered value.
  function automatic logic [W-1:0] sel_model(input logic [W-1:0] a,
                                             input logic [W-1:0] b,
                                             input logic s);
    logic [W-1:0] m;
    m = s ? '1 : '0;
    return (a & m) | (b & ~m);
  endfunction

  function automatic logic par_model(input logic [W-1:0] v);
    return ($countones(v) % 2) == 1;
  endfunction

  logic [W-1:0] mq;
  bit           mq_valid = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      mq       <= '0;
      mq_valid <= 1'b1;
    end else if (en) begin
      mq <= sel_model(A, B, S);
    end
  end

  task automatic check(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Every negedge: combinational output always, registered output once reset seen.
  always @(negedge clk) begin
    if (!done) begin
      check("model_value", value, sel_model(A, B, S));
      if (mq_valid) check("model_value_q", value_q, mq);
`ifdef MUX_8_1_PARITY_EN
      check("model_parity", {{(W-1){1'b0}}, parity}, {{(W-1){1'b0}}, par_model(sel_model(A, B, S))});
      if (mq_valid) check("model_parity_q", {{(W-1){1'b0}}, parity_q}, {{(W-1){1'b0}}, par_model(mq)});
`endif
    end
  end

  logic [W-1:0] va [6];
  logic [W-1:0] vb [6];
  logic         vs [6];
  logic         ve [6];

  initial begin
    // Combinational path, no clock edge dependence.
    A = 8'b01100101; B = 8'b10101100; S = SEL_B;
    #10 check("sel_b", value, 8'b10101100);
    S = SEL_A;
    #1 check("sel_a_immediate", value, 8'b01100101);
    #9 check("sel_a", value, 8'b01100101);

    // Reset with en=1: value_q clears, value unaffected.
    @(negedge clk);
    reset = 1'b1; en = 1'b1;
    @(negedge clk);
    check("reset_q", value_q, 8'h00);
    check("value_in_reset", value, 8'b01100101);

    // Load then hold.
    reset = 1'b0; en = 1'b1; S = SEL_A; A = 8'hA5;
    @(negedge clk);
    check("load_a5", value_q, 8'hA5);
    en = 1'b0; A = 8'h3C;
    @(negedge clk);
    check("hold_q", value_q, 8'hA5);
    check("value_3c", value, 8'h3C);

    // Reset priority over enable.
    S = SEL_B; en = 1'b1; B = 8'hFF; reset = 1'b1;
    @(negedge clk);
    check("reset_prio", value_q, 8'h00);
    check("value_ff", value, 8'hFF);
    reset = 1'b0;
    @(negedge clk);
    check("load_ff", value_q, 8'hFF);

`ifdef MUX_8_1_PARITY_EN
    A = 8'b00000111; S = SEL_A; en = 1'b1;
    #1 check("parity_comb", {7'd0, parity}, 8'd1);
    @(negedge clk);
    check("parity_q_load", {7'd0, parity_q}, 8'd1);
    reset = 1'b1;
    @(negedge clk);
    check("parity_q_reset", {7'd0, parity_q}, 8'd0);
    reset = 1'b0;
`endif

    // Directed table exercising alternating select, enable and boundary data.
    va = '{8'h00, 8'hFF, 8'h81, 8'h7E, 8'h55, 8'hC3};
    vb = '{8'hFF, 8'h00, 8'h18, 8'hAA, 8'h01, 8'h80};
    vs = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    ve = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 6; i++) begin
      A = va[i]; B = vb[i]; S = vs[i]; en = ve[i];
      @(negedge clk);
    end
    // Last enabled load was vector 4 (S=1 -> A=8'h55); vector 5 holds it.
    check("table_final_q", value_q, 8'h55);
    check("table_final_value", value, 8'h80);

    en = 1'b0;
    @(negedge clk);
    done = 1'b1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/mux_8_1.md
Name: mux_8_1

Overview:
- Two-input, 8-bit-wide select multiplexer used in the emulator datapath: S=1 selects A, S=0 selects B.
- Primary output `value` is purely combinational, with zero latency.
- A registered copy `value_q` is provided for pipelined consumers. It is updated on a clock enable and cleared by reset.

Parameters:
- WIDTH, 8, data width of A, B, value and value_q.
  - Must be ≥1.
  - The default of 8 is the only configuration required by the datapath.

Ports:
- clk  input  1  system clock; rising edge active.
- reset  input  1  synchronous, active-high reset. Sampled on the rising edge of clk.
- A  input  WIDTH  data input selected when S=1.
- B  input  WIDTH  data input selected when S=0.
- S  input  1  select.
- en  input  1  load enable for value_q.
- value  output  WIDTH  combinational mux result.
- value_q  output  WIDTH  registered mux result.

Behaviour:
- value = S ? A : B, continuously. There is no clock involvement, and a change on A, B or S propagates within the same timestep.
  - S=0: value==B bit-exact. S=1: value==A bit-exact.
- reset and en have no effect on `value`. `value` is valid during and after reset.
- S unknown (X/Z):
  - value bits where A and B agree equal that bit.
  - All other bits are X (ternary-operator semantics).
  - No latch is inferred.
- value_q, on each rising clk edge:
  - reset=1 → value_q <= 0. Reset has priority over en.
  - else en=1 → value_q <= (S ? A : B), sampled at that edge.
  - else → value_q holds.
- Latency:
  - value: 0 cycles.
  - value_q: 1 cycle after the enabled edge.
- Reset mid-operation: value_q clears on the next edge regardless of en. The combinational path continues unaffected.
- Power-up state before the first reset edge is undefined. The verification environment must not check value_q before reset.
- No handshake and no state machine.

Optional Feature:
- Macro: MUX_8_1_PARITY_EN.
- Defined: adds outputs `parity` (1 bit, combinational, = XOR of all bits of value) and `parity_q` (1 bit, registered alongside value_q).
  - parity_q follows the same reset, enable and hold rules as value_q.
  - parity_q resets to 0.
- Undefined: the parity ports do not exist. No logic is generated.

Decomposition:
- Shared package mux_pkg:
  - constant MUX_DEFAULT_WIDTH = 8.
  - constants SEL_A = 1'b1 and SEL_B = 1'b0 for readable select encoding in callers and the bench.
- One natural sub-module: mux_8_1_reg.
  - WIDTH-bit register with sync active-high reset and enable.
  - Instantiated for value_q and, when enabled, for parity_q.
- The combinational select stays in the top module.

Test Plan:
- A=8'b01100101, B=8'b10101100, S=0, wait 10 time units → value==8'b10101100.
- Same A/B, S=1, wait 10 time units → value==8'b01100101, with no clock edges required.
- Assert reset=1 for one edge with en=1 → value_q==0. value still equals the selected input during reset.
- reset=0, en=1, S=1, A=8'hA5 → after one edge value_q==8'hA5. Then en=0, A=8'h3C → value_q holds 8'hA5 while value==8'h3C.
- S=0, en=1, B=8'hFF, then reset=1 and en=1 on the same edge → value_q==0 (reset priority).
- With MUX_8_1_PARITY_EN defined:
  - A=8'b00000111, S=1 → parity==1.
  - After an enabled edge, parity_q==1.
  - Reset → parity_q==0.
